// File: rtl/push_conditioner.sv
// Push-button conditioner: 2-flop sync, per-bit debounce FSM, one-cycle active-low pulses with lockout.
// Optional auto-repeat while held is enabled by defining PUSH_AUTO_REPEAT_EN.
module push_conditioner #(
  parameter int DB_CYC  = 4,
  parameter int RPT_DLY = 50,
  parameter int RPT_PER = 10
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Push_i,
  output logic [1:0] Push_o,
  output logic [1:0] Held_o
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [7:0] DB_MAX = 8'(DB_CYC);

  if (DB_CYC < 1 || DB_CYC > 255 || RPT_DLY < 1 || RPT_DLY > 65535 ||
      RPT_PER < 1 || RPT_PER > 65535) begin : g_cfg_check
    $error("push_conditioner: parameter out of range");
  end

  logic [1:0] sync1_q, sync2_q;
  state_t     state_q [2];
  state_t     state_d [2];
  logic [7:0] cnt_q   [2];
  logic [7:0] cnt_d   [2];
  logic [1:0] holding_q, holding_d, entry, rptFire, push_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= Push_i;
      sync2_q <= sync1_q;
    end
  end

  // Each FSM counts the sample that leaves IDLE/HELD as the first stable sample.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      case (state_q[b])
        IDLE: begin
          if (!sync2_q[b]) begin
            state_d[b] = (DB_MAX == 8'd1) ? HELD : PRESS_DB;
            cnt_d[b]   = (DB_MAX == 8'd1) ? 8'd0 : 8'd1;
          end
        end
        PRESS_DB: begin
          if (sync2_q[b]) begin
            state_d[b] = IDLE;
            cnt_d[b]   = 8'd0;
          end else if (cnt_q[b] >= DB_MAX - 8'd1) begin
            state_d[b] = HELD;
            cnt_d[b]   = 8'd0;
          end else begin
            cnt_d[b] = (cnt_q[b] == 8'hFF) ? cnt_q[b] : cnt_q[b] + 8'd1;
          end
        end
        HELD: begin
          if (sync2_q[b]) begin
            state_d[b] = (DB_MAX == 8'd1) ? IDLE : REL_DB;
            cnt_d[b]   = (DB_MAX == 8'd1) ? 8'd0 : 8'd1;
          end
        end
        REL_DB: begin
          if (!sync2_q[b]) begin
            state_d[b] = HELD;
            cnt_d[b]   = 8'd0;
          end else if (cnt_q[b] >= DB_MAX - 8'd1) begin
            state_d[b] = IDLE;
            cnt_d[b]   = 8'd0;
          end else begin
            cnt_d[b] = (cnt_q[b] == 8'hFF) ? cnt_q[b] : cnt_q[b] + 8'd1;
          end
        end
        default: begin
          state_d[b] = IDLE;
          cnt_d[b]   = 8'd0;
        end
      endcase
      holding_q[b] = (state_q[b] == HELD) || (state_q[b] == REL_DB);
      holding_d[b] = (state_d[b] == HELD) || (state_d[b] == REL_DB);
      entry[b]     = (state_d[b] == HELD) && !holding_q[b];
    end
  end

`ifdef PUSH_AUTO_REPEAT_EN
  localparam logic [15:0] DLY_LAST = 16'(RPT_DLY - 1);
  localparam logic [15:0] PER_LAST = 16'(RPT_PER - 1);

  logic [15:0] rpt_q [2];
  logic [15:0] rpt_d [2];
  logic [1:0]  rptFirst_q, rptFirst_d;

  // The timer only advances on HELD->HELD edges, so REL_DB freezes it.
  always_comb begin
    rptFire    = 2'b00;
    rptFirst_d = rptFirst_q;
    for (int b = 0; b < 2; b++) begin
      rpt_d[b] = rpt_q[b];
      if (entry[b]) begin
        rpt_d[b]      = 16'd0;
        rptFirst_d[b] = 1'b0;
      end else if (state_q[b] == HELD && state_d[b] == HELD) begin
        if (!rptFirst_q[b] && rpt_q[b] >= DLY_LAST) begin
          rptFire[b]    = 1'b1;
          rpt_d[b]      = 16'd0;
          rptFirst_d[b] = 1'b1;
        end else if (rptFirst_q[b] && rpt_q[b] >= PER_LAST) begin
          rptFire[b] = 1'b1;
          rpt_d[b]   = 16'd0;
        end else begin
          rpt_d[b] = (rpt_q[b] == 16'hFFFF) ? rpt_q[b] : rpt_q[b] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rptFirst_q <= 2'b00;
      for (int b = 0; b < 2; b++) rpt_q[b] <= 16'd0;
    end else begin
      rptFirst_q <= rptFirst_d;
      for (int b = 0; b < 2; b++) rpt_q[b] <= rpt_d[b];
    end
  end
`else
  assign rptFire = 2'b00;
`endif

  // Lockout: a new press or repeat is swallowed whenever the other button is also down.
  always_comb begin
    push_d[0] = (entry[0] && !entry[1] && !holding_q[1]) ||
                (rptFire[0] && !holding_q[1] && !holding_d[1]);
    push_d[1] = (entry[1] && !entry[0] && !holding_q[0]) ||
                (rptFire[1] && !holding_q[0] && !holding_d[0]);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= IDLE;
        cnt_q[b]   <= 8'd0;
      end
      Push_o <= 2'b11;
      Held_o <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      Push_o <= ~push_d;
      Held_o <= holding_d;
    end
  end

endmodule

// File: tb/tb_push_conditioner.sv
// Scoreboard bench for push_conditioner: stimulus queues expected pulses, a monitor checks every pulse seen.
module tb_push_conditioner;

  logic       Clk;
  logic       Rst;
  logic [1:0] Push_i;
  logic [1:0] Push_o;
  logic [1:0] Held_o;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  typedef struct {
    logic [1:0] pat;
    int         cyc;
  } pulse_t;

  pulse_t expQ[$];

  push_conditioner #(.DB_CYC(4), .RPT_DLY(50), .RPT_PER(10)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Push_i(Push_i),
    .Push_o(Push_o),
    .Held_o(Held_o)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  // Monitor: every non-idle Push_o must match the head of the expected-pulse queue.
  always @(negedge Clk) begin
    if (Rst && Push_o !== 2'b11) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: got Push_o=%b at cycle %0d, required none", Push_o, cycleCnt);
      end else begin
        pulse_t e;
        e = expQ.pop_front();
        if (Push_o !== e.pat || cycleCnt != e.cyc) begin
          errors++;
          $display("[TB] FAIL pulse: got Push_o=%b at cycle %0d, required %b at cycle %0d",
                   Push_o, cycleCnt, e.pat, e.cyc);
        end
      end
    end
  end

  task automatic expectPulse(input logic [1:0] pat, input int cyc);
    pulse_t e;
    e.pat = pat;
    e.cyc = cyc;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [1:0] p, input int n);
    Push_i = p;
    repeat (n) @(negedge Clk);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic pulseReset(output int relCycle);
    #2 Rst = 1'b0;
    #1;
    checkOutput("reset_push", Push_o, 2'b11);
    checkOutput("reset_held", Held_o, 2'b00);
    #29 Rst = 1'b1;
    relCycle = cycleCnt;
  endtask

  initial begin
    int k;
    int e;
    Rst    = 1'b0;
    Push_i = 2'b11;
    #35;
    checkOutput("por_push", Push_o, 2'b11);
    checkOutput("por_held", Held_o, 2'b00);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);

    $display("[TB] clean press on bit1");
    k = cycleCnt;
    expectPulse(2'b01, k + 6);
    applyStimulus(2'b01, 10);
    checkOutput("clean_held", Held_o, 2'b10);
    applyStimulus(2'b11, 12);
    checkOutput("clean_release", Held_o, 2'b00);

    $display("[TB] bounce on bit0");
    for (int i = 0; i < 4; i++) applyStimulus((i % 2 == 0) ? 2'b10 : 2'b11, 2);
    checkOutput("bounce_held", Held_o, 2'b00);
    k = cycleCnt;
    expectPulse(2'b10, k + 6);
    applyStimulus(2'b10, 12);
    checkOutput("bounce_after", Held_o, 2'b01);
    applyStimulus(2'b11, 12);
    checkOutput("bounce_release", Held_o, 2'b00);

    $display("[TB] short glitch");
    applyStimulus(2'b01, 3);
    checkOutput("glitch_held", Held_o, 2'b00);
    applyStimulus(2'b11, 8);

    $display("[TB] simultaneous press");
    applyStimulus(2'b00, 20);
    checkOutput("simul_held", Held_o, 2'b11);
    applyStimulus(2'b11, 12);
    checkOutput("simul_release", Held_o, 2'b00);

    $display("[TB] overlapping press");
    k = cycleCnt;
    expectPulse(2'b01, k + 6);
    applyStimulus(2'b01, 5);
    applyStimulus(2'b00, 15);
    checkOutput("overlap_held", Held_o, 2'b11);
    applyStimulus(2'b11, 12);
    checkOutput("overlap_release", Held_o, 2'b00);

    $display("[TB] reset during debounce and during hold");
    applyStimulus(2'b10, 3);
    pulseReset(e);
    expectPulse(2'b10, e + 6);
    @(negedge Clk);
    repeat (10) @(negedge Clk);
    checkOutput("rst_press_held", Held_o, 2'b01);
    pulseReset(e);
    expectPulse(2'b10, e + 6);
    @(negedge Clk);
    repeat (10) @(negedge Clk);
    checkOutput("rst_held_again", Held_o, 2'b01);
    applyStimulus(2'b11, 12);
    checkOutput("rst_release", Held_o, 2'b00);

    $display("[TB] long hold on bit1");
    k = cycleCnt;
    expectPulse(2'b01, k + 6);
`ifdef PUSH_AUTO_REPEAT_EN
    expectPulse(2'b01, k + 56);
    for (int i = 1; i <= 4; i++) expectPulse(2'b01, k + 56 + 10 * i);
`endif
    applyStimulus(2'b01, 100);
    checkOutput("long_held", Held_o, 2'b10);
    applyStimulus(2'b11, 15);
    checkOutput("long_release", Held_o, 2'b00);

    foreach (expQ[i]) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_pulse: got no pulse, required %b at cycle %0d", expQ[i].pat, expQ[i].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/push_conditioner.md
PUSH_CONDITIONER -- requirements
Module: push_conditioner

Interface
REQ-001 SHALL have parameter DB_CYC, default 4, consecutive stable synchronized samples needed to accept a press or release (range 1..255).
REQ-002 SHALL have parameter RPT_DLY, default 50, cycles in HELD before the first auto-repeat pulse (range 1..65535).
REQ-003 SHALL have parameter RPT_PER, default 10, cycles between subsequent auto-repeat pulses (range 1..65535).
REQ-004 SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Push_i  input  2  raw active-low buttons, asynchronous to Clk; bit1 = up, bit0 = down; idle 2'b11.
REQ-007 SHALL have port Push_o  output  2  conditioned active-low one-cycle pulses, same bit mapping, idle 2'b11; drives the BCD counter Push input directly.
REQ-008 SHALL have port Held_o  output  2  active-high debounced pressed level per bit.

Function
REQ-009 SHALL pass each Push_i bit through a 2-flop synchronizer before any other logic.
REQ-010 SHALL run one FSM per bit with states IDLE, PRESS_DB, HELD, REL_DB and an 8-bit stability counter.
REQ-011 IDLE -> PRESS_DB when the synchronized bit is 0; PRESS_DB -> IDLE if it returns to 1 before DB_CYC consecutive low samples; PRESS_DB -> HELD on the DB_CYC-th consecutive low sample.
REQ-012 HELD -> REL_DB when the synchronized bit is 1; REL_DB -> HELD if it returns to 0 before DB_CYC consecutive high samples; REL_DB -> IDLE on the DB_CYC-th consecutive high sample.
REQ-013 Entry to HELD SHALL drive the matching Push_o bit to 0 for exactly one cycle.
REQ-014 For a clean press, that pulse SHALL appear in the cycle after rising edge DB_CYC+2, counting the first edge that samples Push_i=0 as edge 1.
REQ-015 Held_o[b] SHALL be 1 in HELD and REL_DB, and 0 in IDLE and PRESS_DB.
REQ-016 Lockout: if both FSMs enter HELD on the same edge, neither bit SHALL pulse.
REQ-017 Lockout: if one FSM enters HELD while the other is in HELD or REL_DB, the new entry SHALL produce no pulse.
REQ-018 Lockout: while both bits are in HELD or REL_DB, Push_o SHALL stay 2'b11, with no auto-repeat on either bit.
REQ-019 Push_o SHALL never be 2'b00.
REQ-020 Glitches shorter than DB_CYC synchronized cycles SHALL produce no pulse and no Held_o change.
REQ-021 Counters SHALL saturate and not wrap.
REQ-022 Outputs SHALL be registered, with no combinational path from Push_i.

Reset
REQ-023 Rst=0 SHALL asynchronously force all FSMs to IDLE, all counters to 0, synchronizer flops to 1, Push_o=2'b11 and Held_o=2'b00.
REQ-024 Rst asserted mid-press SHALL discard the press; after release of Rst, a button still held SHALL be debounced afresh and yield one pulse.

Configuration
REQ-025 With macro PUSH_AUTO_REPEAT_EN defined, a bit held in HELD SHALL pulse again RPT_DLY cycles after the HELD-entry pulse, then every RPT_PER cycles until leaving HELD.
REQ-026 With PUSH_AUTO_REPEAT_EN defined, REL_DB SHALL pause the repeat timer, and a return to HELD SHALL resume it.
REQ-027 Without PUSH_AUTO_REPEAT_EN, exactly one pulse per accepted press SHALL be produced and the RPT_* parameters SHALL be unused.

Verification
REQ-028 SHALL cover clean press: 20 ns clock, defaults, Push_i=2'b01 for 200 ns then 2'b11 -> Push_o[1] low for one cycle after edge 6 and Held_o[1] high.
REQ-029 SHALL cover bounce: Push_i[0] toggled every 40 ns for 200 ns, then held low for 200 ns -> exactly one Push_o[0] pulse, no pulse during bounce.
REQ-030 SHALL cover simultaneous press: Push_i=2'b00 for 400 ns -> Push_o stays 2'b11 and Held_o=2'b11.
REQ-031 SHALL cover overlap: bit1 pressed, then bit0 pressed 100 ns later, both held -> one Push_o[1] pulse only.
REQ-032 SHALL cover reset: Rst=0 for 30 ns during PRESS_DB -> Push_o=2'b11 and Held_o=0 immediately, then one pulse DB_CYC+2 edges after Rst rises.
REQ-033 SHALL cover auto-repeat (macro on): bit1 held 2000 ns (100 cycles) -> pulses at cycles 6, 56, 66, 76, 86, 96.
